toggle_event_arbiter: RTL and testbench
=======================================

# toggle_event_arbiter

Source-domain scheduler that shares one toggle-synchronizer CDC channel among `N_REQ` event requesters. It queues single-cycle event pulses and grants them round-robin. For each grant it drives a stable `chan_id` and then flips `toggle_out`. Between flips it enforces a minimum spacing, so the destination-side XOR edge detector never merges two events.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `GAP`, 6: hold-off cycles after a flip, ≥1. Must cover destination sync latency (2 dest FFs + 1 capture FF) in source cycles.
- `ID_W`, localparam = `$clog2(N_REQ)`: width of `chan_id`.
- `clk` input 1: single clock, the source domain of the CDC channel.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_pulse` input `N_REQ`: one-cycle event pulses, bit i is requester i.
- `ovf_clr` input 1: synchronous clear of all `ovf` bits.
- `toggle_out` output 1: toggle bit driving the CDC synchronizer.
- `chan_id` output `ID_W`: index of the granted requester. Stable from one cycle before a flip until the next grant.
- `pend` output `N_REQ`: per-requester pending flags.
- `busy` output 1: high in LAUNCH and HOLD.
- `ovf` output `N_REQ`: sticky drop flags, one per requester.
- `drop_cnt` output 8: only when `TOGGLE_ARB_DROP_CNT_EN` is defined.

## Operation
- **Reset values:** all outputs and state are 0, including `toggle_out`, `chan_id`, `pend`, `ovf`, `busy` and `drop_cnt`; the FSM is in IDLE; the round-robin pointer is 0.
- **Pending capture:** on a clock edge, if `req_pulse[i]` is high then `pend[i]` is set.
- **Drops:** if `pend[i]` is already 1 and is not being cleared that same edge, the pulse is dropped. `ovf[i]` is set, and `drop_cnt` increments (saturating at 255).
- **Request on grant edge:** a pulse on the edge that clears `pend[i]` by grant leaves `pend[i]` at 1. This counts as a new queued event, not a drop.
- **FSM states:** IDLE, LAUNCH, HOLD.
- **IDLE:** if any `pend` is set, select the first set bit at or after the pointer, wrapping at `N_REQ`. Then register `chan_id` to the winner, clear that `pend` bit, set the pointer to winner+1 mod `N_REQ`, and go to LAUNCH. Otherwise stay in IDLE.
- **LAUNCH** (one cycle): invert `toggle_out`, load the hold counter with `GAP-1`, go to HOLD.
- **HOLD:** decrement the counter. When it reads 0, go to IDLE. `chan_id` is frozen throughout.
- **`ovf_clr`:** clears `ovf` and `drop_cnt`. An overflow on the same edge wins, so the flag stays set.
- **Reset mid-operation:** returns to the reset state immediately and discards queued events. The destination domain must be reset together with this block, because a `toggle_out` change caused by reset would otherwise be seen as a spurious event.

## Timing
- A pulse sampled at edge E0 sets `pend` after E0.
- Grant happens at E1: `chan_id` is valid and `busy` is 1 after E1.
- The flip happens at E2. Latency from pulse to flip is 2 edges when IDLE.
- The minimum spacing between consecutive flips is `GAP`+2 cycles: LAUNCH, then `GAP` HOLD cycles, then one IDLE grant cycle.
- `chan_id` is stable at least 1 cycle before each flip and for `GAP`+1 cycles after it.

## Configuration
- **`TOGGLE_ARB_DROP_CNT_EN` defined:** the 8-bit `drop_cnt` port and its counter exist. The counter counts every dropped pulse across all requesters, saturates at 255, and is cleared by `ovf_clr` or reset.
- **`TOGGLE_ARB_DROP_CNT_EN` undefined:** neither the port nor the counter exists. Only the sticky `ovf` bits report drops, and all other behaviour is identical.

## Test plan
All scenarios use `N_REQ`=4 and `GAP`=6.

1. **Single event:** reset, then `req_pulse`=0001 for one cycle. Required: `chan_id`=0 one cycle before the flip; `toggle_out` goes 0→1 two edges after the pulse edge; `busy` is high for 7 cycles; `pend` ends at 0000.
2. **Simultaneous requests:** `req_pulse`=1111 in one cycle. Required: grants in order 0,1,2,3; four `toggle_out` flips spaced exactly 8 cycles apart; `chan_id` matches each grant; `ovf`=0000.
3. **Round-robin fairness and wrap:** requester 3 has just been granted; then assert 1001 together. Required: requester 0 is granted next (pointer wrapped), then requester 3.
4. **Overflow:** assert `req_pulse[2]` twice while `pend[2]` is 1 during another grant's HOLD. Required: `ovf`=0100; `drop_cnt`=2 when the macro is defined; only one event is issued for requester 2.
5. **Grant-edge request:** `req_pulse[1]` pulses on the same edge that grants requester 1. Required: `pend[1]` stays 1, `ovf[1]` stays 0, and requester 1 gets a second flip 8 cycles after its first.
6. **Reset in HOLD:** assert `rst_n`=0 in the third HOLD cycle with `pend`=0110. Required: `toggle_out`, `chan_id`, `pend`, `busy` and `ovf` all read 0 immediately; no flip occurs after release until a new pulse arrives.

Source files
------------

// File: rtl/toggle_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_arbiter
//  Purpose  : Source-domain scheduler that shares one toggle-synchronizer CDC
//             channel among N_REQ event requesters. Single-cycle event pulses
//             are queued as per-requester pending flags and granted
//             round-robin. For each grant, chan_id is driven and held stable.
//             toggle_out is then flipped. A hold-off of GAP cycles follows
//             each flip, so the destination XOR edge detector never merges
//             two events.
//
//  Ports    : clk        - source-domain clock
//             rst_n      - asynchronous active-low reset
//             req_pulse  - [N_REQ] one-cycle event pulses, bit i = requester i
//             ovf_clr    - synchronous clear of ovf (and drop_cnt)
//             toggle_out - toggle bit into the CDC synchronizer
//             chan_id    - [ID_W] index of the granted requester
//             pend       - [N_REQ] per-requester pending flags
//             busy       - high while in LAUNCH or HOLD
//             ovf        - [N_REQ] sticky drop flags
//             drop_cnt   - [8] saturating count of dropped pulses
//                          (present only with TOGGLE_ARB_DROP_CNT_EN)
//
//  Options  : `define TOGGLE_ARB_DROP_CNT_EN to add the drop_cnt port/counter.
//
//  Note     : the destination domain must be reset together with this block.
//             A reset-induced change on toggle_out would otherwise be seen
//             there as a spurious event.
//
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_event_arbiter #(
   parameter int N_REQ = 4,   // number of requesters, 2..16
   parameter int GAP   = 6,   // hold-off cycles after a flip, >= 1
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_pulse,
   input  logic             ovf_clr,
   output logic             toggle_out,
   output logic [ID_W-1:0]  chan_id,
   output logic [N_REQ-1:0] pend,
   output logic             busy,
   output logic [N_REQ-1:0] ovf
`ifdef TOGGLE_ARB_DROP_CNT_EN
   ,
   output logic [7:0]       drop_cnt
`endif
);

   // Hold counter must represent GAP-1; keep it at least one bit wide.
   localparam int c_CNT_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_LAUNCH = 2'd1;
   localparam logic [1:0] c_HOLD   = 2'd2;

   logic [1:0]         r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_chan_id;
   logic               r_toggle;
   logic [N_REQ-1:0]   r_pend;
   logic [N_REQ-1:0]   r_ovf;
   logic [c_CNT_W-1:0] r_cnt;

   logic               w_grant;
   logic               w_found;
   logic [ID_W-1:0]    w_idx;
   logic [ID_W-1:0]    w_winner;
   logic [ID_W-1:0]    w_ptr_nxt;
   logic [N_REQ-1:0]   w_clr;
   logic [N_REQ-1:0]   w_drop;
   logic [N_REQ-1:0]   w_pend_nxt;
   logic [N_REQ-1:0]   w_ovf_nxt;

   // ------------------------------------------------------------------------
   // Round-robin pick: walk from the pointer upward, wrapping at N_REQ, and
   // take the first pending requester. The walk index is kept at ID_W bits
   // so that it wraps explicitly for non-power-of-two N_REQ.
   // ------------------------------------------------------------------------
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = r_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && r_pend[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
         if (w_idx == ID_W'(N_REQ - 1)) begin
            w_idx = '0;
         end else begin
            w_idx = w_idx + ID_W'(1);
         end
      end
   end

   assign w_ptr_nxt = (w_winner == ID_W'(N_REQ - 1)) ? '0 : (w_winner + ID_W'(1));
   assign w_grant   = (r_state == c_IDLE) && w_found;
   assign w_clr     = w_grant ? (N_REQ'(1) << w_winner) : '0;

   // A pulse on a bit that stays pending this edge is a drop. A pulse on
   // the bit being granted re-queues it instead, because that bit's
   // previous event has just been consumed.
   assign w_drop     = req_pulse & r_pend & ~w_clr;
   assign w_pend_nxt = (r_pend & ~w_clr) | req_pulse;
   // A drop coinciding with ovf_clr keeps its flag set.
   assign w_ovf_nxt  = (ovf_clr ? '0 : r_ovf) | w_drop;

   // ------------------------------------------------------------------------
   // Pending/overflow flags and the IDLE -> LAUNCH -> HOLD sequencer.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_IDLE;
         r_ptr     <= '0;
         r_chan_id <= '0;
         r_toggle  <= 1'b0;
         r_pend    <= '0;
         r_ovf     <= '0;
         r_cnt     <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_ovf  <= w_ovf_nxt;
         case (r_state)
            c_IDLE: begin
               if (w_grant) begin
                  r_chan_id <= w_winner;
                  r_ptr     <= w_ptr_nxt;
                  r_state   <= c_LAUNCH;
               end
            end
            c_LAUNCH: begin
               // chan_id has been stable for one cycle when the flip occurs.
               r_toggle <= ~r_toggle;
               r_cnt    <= c_CNT_W'(GAP - 1);
               r_state  <= c_HOLD;
            end
            c_HOLD: begin
               // GAP HOLD cycles in total: GAP-1 down to 0 inclusive.
               if (r_cnt == '0) begin
                  r_state <= c_IDLE;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

`ifdef TOGGLE_ARB_DROP_CNT_EN
   // ------------------------------------------------------------------------
   // Saturating count of all dropped pulses. Drops on the same edge as
   // ovf_clr are counted into the freshly cleared value.
   // ------------------------------------------------------------------------
   logic [7:0] r_drop_cnt;
   logic [8:0] w_drop_num;
   logic [8:0] w_cnt_sum;

   always_comb begin
      w_drop_num = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_drop_num = w_drop_num + 9'(w_drop[i]);
      end
      w_cnt_sum = (ovf_clr ? 9'd0 : {1'b0, r_drop_cnt}) + w_drop_num;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_cnt_sum > 9'd255) begin
         r_drop_cnt <= 8'd255;
      end else begin
         r_drop_cnt <= w_cnt_sum[7:0];
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   // Without the counter, drops are reported only through the sticky ovf bits.
`endif

   assign toggle_out = r_toggle;
   assign chan_id    = r_chan_id;
   assign pend       = r_pend;
   assign ovf        = r_ovf;
   assign busy       = (r_state == c_LAUNCH) || (r_state == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_event_arbiter
//  Purpose  : Directed self-checking bench for toggle_event_arbiter with
//             N_REQ=4 and GAP=6. Expected values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_event_arbiter;

   localparam int N_REQ = 4;
   localparam int GAP   = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_pulse = '0;
   logic       ovf_clr = 1'b0;
   logic       toggle_out;
   logic [1:0] chan_id;
   logic [3:0] pend;
   logic       busy;
   logic [3:0] ovf;
`ifdef TOGGLE_ARB_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;
   int e0;
   int bc;
   int nfl;
   int fl_cyc [8];
   int fl_id  [8];

   toggle_event_arbiter #(.N_REQ(N_REQ), .GAP(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_pulse  (req_pulse),
      .ovf_clr    (ovf_clr),
      .toggle_out (toggle_out),
      .chan_id    (chan_id),
      .pend       (pend),
      .busy       (busy),
      .ovf        (ovf)
`ifdef TOGGLE_ARB_DROP_CNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      req_pulse = '0;
      ovf_clr   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Record every toggle_out change over a fixed window of cycles.
   task automatic capture(input int n_ticks);
      logic prev;
      nfl  = 0;
      prev = toggle_out;
      for (int i = 0; i < n_ticks; i++) begin
         tick();
         if (toggle_out !== prev) begin
            if (nfl < 8) begin
               fl_cyc[nfl] = cyc;
               fl_id[nfl]  = int'(chan_id);
            end
            nfl++;
            prev = toggle_out;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      chk("rst_toggle", toggle_out, 0);
      chk("rst_chan_id", chan_id, 0);
      chk("rst_pend", pend, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
`ifdef TOGGLE_ARB_DROP_CNT_EN
      chk("rst_drop_cnt", drop_cnt, 0);
`endif

      // ---------------- 1: single event ----------------
      req_pulse = 4'b0001;
      tick();                           // E0
      req_pulse = '0;
      chk("s1_pend_after_e0", pend, 4'b0001);
      chk("s1_busy_after_e0", busy, 0);
      tick();                           // E1: grant
      chk("s1_chan_id_pre_flip", chan_id, 0);
      chk("s1_busy_after_e1", busy, 1);
      chk("s1_toggle_pre_flip", toggle_out, 0);
      chk("s1_pend_after_grant", pend, 0);
      tick();                           // E2: flip
      chk("s1_toggle_flip", toggle_out, 1);
      bc = 1;
      for (int i = 0; i < 20 && busy; i++) begin
         bc++;
         tick();
      end
      chk("s1_busy_cycles", bc, 7);
      chk("s1_pend_end", pend, 0);

      // ---------------- 2: simultaneous requests ----------------
      do_reset();
      req_pulse = 4'b1111;
      tick();
      req_pulse = '0;
      e0 = cyc;
      capture(40);
      chk("s2_flip_count", nfl, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("s2_grant%0d_id", k), fl_id[k], k);
         chk($sformatf("s2_flip%0d_time", k), fl_cyc[k] - e0, 2 + 8 * k);
      end
      chk("s2_ovf", ovf, 0);
      chk("s2_idle", busy, 0);

      // ---------------- 3: round-robin wrap ----------------
      req_pulse = 4'b1001;
      tick();
      req_pulse = '0;
      e0 = cyc;
      capture(20);
      chk("s3_flip_count", nfl, 2);
      chk("s3_first_id", fl_id[0], 0);
      chk("s3_second_id", fl_id[1], 3);
      chk("s3_second_time", fl_cyc[1] - e0, 10);

      // ---------------- 4: overflow ----------------
      do_reset();
      req_pulse = 4'b0001;
      tick();                           // E0
      req_pulse = '0;
      tick();                           // E1 grant 0
      tick();                           // E2 flip, HOLD
      req_pulse = 4'b0100;
      tick();                           // E3 queue req 2
      req_pulse = '0;
      chk("s4_pend2", pend, 4'b0100);
      chk("s4_no_ovf_yet", ovf, 0);
      tick();
      req_pulse = 4'b0100;
      tick();                           // E5 drop 1
      req_pulse = '0;
      tick();
      req_pulse = 4'b0100;
      tick();                           // E7 drop 2
      req_pulse = '0;
      chk("s4_ovf", ovf, 4'b0100);
`ifdef TOGGLE_ARB_DROP_CNT_EN
      chk("s4_drop_cnt", drop_cnt, 2);
`endif
      capture(20);
      chk("s4_flip_count", nfl, 1);
      chk("s4_flip_id", fl_id[0], 2);
      chk("s4_ovf_sticky", ovf, 4'b0100);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("s4_ovf_cleared", ovf, 0);
`ifdef TOGGLE_ARB_DROP_CNT_EN
      chk("s4_drop_cnt_cleared", drop_cnt, 0);
`endif

      // ---------------- 5: grant-edge request ----------------
      do_reset();
      req_pulse = 4'b0010;
      tick();                           // E0 queue req 1
      e0 = cyc;
      tick();                           // E1 grant 1 with a new pulse
      req_pulse = '0;
      chk("s5_chan_id", chan_id, 1);
      chk("s5_pend_kept", pend, 4'b0010);
      chk("s5_no_ovf", ovf, 0);
      capture(20);
      chk("s5_flip_count", nfl, 2);
      chk("s5_first_time", fl_cyc[0] - e0, 2);
      chk("s5_second_time", fl_cyc[1] - e0, 10);
      chk("s5_second_id", fl_id[1], 1);
      chk("s5_ovf_end", ovf, 0);

      // ---------------- 6: reset in HOLD ----------------
      do_reset();
      req_pulse = 4'b1000;
      tick();                           // E0
      req_pulse = '0;
      tick();                           // E1 grant 3
      tick();                           // E2 flip
      req_pulse = 4'b0110;
      tick();                           // E3 queue 1,2
      req_pulse = 4'b0100;
      tick();                           // E4 drop on 2; third HOLD cycle
      req_pulse = '0;
      chk("s6_pre_pend", pend, 4'b0110);
      chk("s6_pre_ovf", ovf, 4'b0100);
      chk("s6_pre_chan_id", chan_id, 3);
      chk("s6_pre_toggle", toggle_out, 1);
      chk("s6_pre_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("s6_rst_toggle", toggle_out, 0);
      chk("s6_rst_chan_id", chan_id, 0);
      chk("s6_rst_pend", pend, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_ovf", ovf, 0);
      tick();
      rst_n = 1'b1;
      capture(20);
      chk("s6_no_flip_after_release", nfl, 0);
      chk("s6_idle_after_release", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
